de0_nano_sopc_pio_key: RTL and testbench
========================================

# de0_nano_sopc_pio_key

Avalon-MM slave input PIO: samples a bank of external input pins (keys/switches) into the `clk` domain, debounces them, and exposes level, edge-capture and interrupt-mask registers to the Nios II. It is the input-direction companion of the LED output PIO and sits on the same system interconnect. It drives a level-sensitive interrupt request to the processor's IRQ input.

## Interface
Parameters:
- `WIDTH`, 4: number of input pins, 1..32.
- `SYNC_STAGES`, 2: synchronizer flops per pin, 2..4.
- `DEBOUNCE_CYCLES`, 0: stable-cycle count required before the filtered level changes; 0 bypasses the filter.
- `EDGE_TYPE`, 0: capture mode; 0 = rising, 1 = falling, 2 = any edge.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  2  word offset of the register.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe, qualified by `chipselect`.
- `writedata`  in  32  write data; bits above `WIDTH` are ignored.
- `in_port`  in  WIDTH  asynchronous external pins.
- `readdata`  out  32  read data; bits above `WIDTH` read 0.
- `irq`  out  1  interrupt request, active high, level.

## Operation
- Register map (word offsets):
  - 0: DATA, read-only, filtered level.
  - 1: reserved, reads 0, writes ignored.
  - 2: IRQ_MASK, read/write.
  - 3: EDGE_CAPTURE, read; writing 1 to a bit clears it, writing 0 has no effect.
- Reads have no side effects. `readdata` is combinational from `address` and selects independently of `chipselect` (zero wait states, read latency 0).
- Synchronizer: `SYNC_STAGES` flops per bit. Each stage resets to 0.
- Debounce, per bit:
  - A counter increments while the synchronized value differs from the filtered value.
  - It clears to 0 on any cycle the two agree.
  - On the cycle it reaches `DEBOUNCE_CYCLES`, the filtered bit takes the synchronized value and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`, and the counter saturates.
  - Filtered resets to 0.
  - When `DEBOUNCE_CYCLES` = 0, filtered equals the synchronized value directly.
- Edge detect: a `prev` register holds the last filtered value and resets to 0. An edge is one of:
  - rising: `filt & ~prev`
  - falling: `~filt & prev`
  - any: `filt ^ prev`
- EDGE_CAPTURE bit sets on a detected edge and holds until cleared by software.
  - If a clear and a new edge hit the same bit in the same cycle, the edge wins and the bit stays 1.
- IRQ_MASK resets to 0. `irq` = OR-reduce(EDGE_CAPTURE & IRQ_MASK), combinational from the registers.
- Pin held at 1 through reset: after release it produces one rising-edge capture once it has propagated. Software clears EDGE_CAPTURE during init.

## Timing
- Pin to DATA latency, with the pin stable and meeting setup: `SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1 clocks.
- DATA to EDGE_CAPTURE: 1 clock. EDGE_CAPTURE to `irq`: 0 clocks.
- Writes commit on the `clk` edge where `chipselect` & ~`write_n`. A read on the following cycle returns the new value.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles after synchronization never reach DATA.
- Reset outputs: `readdata` reflects all-zero registers; `irq` = 0.
- Reset asserted mid-debounce or mid-capture clears all state immediately, asynchronously.

## Structure
- Shared package `pio_pkg`:
  - register offsets `PIO_DATA`, `PIO_MASK`, `PIO_EDGE`.
  - edge-mode constants `EDGE_RISE`, `EDGE_FALL`, `EDGE_ANY`.
- Sub-module `pio_in_debounce`: one bit, holding the synchronizer, counter and filtered flop. It is instantiated `WIDTH` times with a generate loop.
- The top level holds the edge detect, the registers, the read mux and `irq`.

## Test plan
- Reset, then read offsets 0, 1, 2 and 3 with `in_port` = 0 → all return 0x0; `irq` = 0.
- `DEBOUNCE_CYCLES`=4, rising mode:
  - Raise `in_port`[1] and hold → DATA = 0x2 exactly 7 clocks later, EDGE_CAPTURE = 0x2 one clock after that.
  - Write IRQ_MASK = 0x2 → `irq` = 1. Write EDGE = 0x2 → `irq` = 0 next cycle.
- Glitch: pulse `in_port`[0] high for 3 clocks with `DEBOUNCE_CYCLES`=4 → DATA, EDGE_CAPTURE and `irq` never change.
- Same-cycle clear and edge: write EDGE = 0x1 on the exact cycle a new rising edge on bit 0 is detected → EDGE_CAPTURE bit 0 reads 1 afterward.
- Any-edge mode with mask 0xF: toggle bit 3 high then low → two captures. Clearing after each toggle leaves bit 3 set again. Writing 0x0 to EDGE leaves it unchanged.
- Assert `reset` while a debounce count is in progress and EDGE_CAPTURE = 0x5 → all registers read 0 while reset is asserted, and no edge is reported from the aborted count.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the input PIO: register offsets, edge-capture
// modes and the debounce counter sizing helper.
package pio_pkg;

    // Word offsets of the Avalon-MM register map
    typedef enum logic [1:0] {
        PIO_DATA = 2'd0,
        PIO_RSVD = 2'd1,
        PIO_MASK = 2'd2,
        PIO_EDGE = 2'd3
    } pio_reg_e;

    // Edge-capture modes selected by EDGE_TYPE
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Counter width able to hold DEBOUNCE_CYCLES; at least one bit so the
    // bypass configuration still elaborates a legal vector.
    function automatic int unsigned dbc_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// One input bit: multi-flop synchronizer followed by a stable-count
// debounce filter. DEBOUNCE_CYCLES = 0 degenerates to a single register
// stage that follows the synchronized value.
module pio_in_debounce
    import pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_filt
);

    localparam int unsigned   CW   = dbc_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_filt;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_filt = r_filt;

    // Shift the asynchronous pin through the synchronizer chain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end

    // Count disagreeing cycles; adopt the new level once the count has
    // reached CMAX. The counter never passes CMAX, so it saturates there.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (w_sync == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == CMAX) begin
            r_filt <= w_sync;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/de0_nano_sopc_pio_key.sv
// Avalon-MM input PIO for keys/switches: debounced level, edge capture
// with write-1-to-clear, interrupt mask and level-sensitive irq.
module de0_nano_sopc_pio_key
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_TYPE       = EDGE_RISE
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic             w_wr;
    logic             w_unused_wdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        pio_in_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_clk  (clk),
            .i_rst  (reset),
            .i_pin  (in_port[g]),
            .o_filt (w_filt[g])
        );
    end

    assign w_wr           = chipselect & ~write_n;
    assign w_clr          = (w_wr && address == PIO_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = ^writedata;
    assign irq            = |(r_cap & r_mask);

    // Select the edge flavour compared against the previous filtered level
    always_comb begin
        w_edge = w_filt & ~r_prev;
        if (EDGE_TYPE == EDGE_FALL)     w_edge = ~w_filt & r_prev;
        else if (EDGE_TYPE == EDGE_ANY) w_edge = w_filt ^ r_prev;
    end

    // Remember last cycle's filtered level for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prev <= '0;
        else       r_prev <= w_filt;
    end

    // Interrupt mask register, software writable
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          r_mask <= '0;
        else if (w_wr && address == PIO_MASK) r_mask <= writedata[WIDTH-1:0];
    end

    // Sticky edge capture; a coincident edge overrides a software clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cap <= '0;
        else       r_cap <= (r_cap & ~w_clr) | w_edge;
    end

    // Zero-latency read mux, independent of chipselect
    always_comb begin
        readdata = '0;
        case (pio_reg_e'(address))
            PIO_DATA: readdata[WIDTH-1:0] = w_filt;
            PIO_MASK: readdata[WIDTH-1:0] = r_mask;
            PIO_EDGE: readdata[WIDTH-1:0] = r_cap;
            default:  readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_de0_nano_sopc_pio_key.sv
// Bench for the input PIO: two instances (rising/4-cycle debounce and
// any-edge/2-cycle debounce) sharing one bus, checked against constants in
// directed scenarios and against a sliding-window model under random pins.
module tb_de0_nano_sopc_pio_key;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  pin_r = '0;
    logic [3:0]  pin_a = '0;
    logic [31:0] rd_r, rd_a;
    logic        irq_r, irq_a;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    de0_nano_sopc_pio_key #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
    ) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(pin_r),
        .readdata(rd_r), .irq(irq_r)
    );

    de0_nano_sopc_pio_key #(
        .WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(2), .EDGE_TYPE(2)
    ) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(pin_a),
        .readdata(rd_a), .irq(irq_a)
    );

    // Reference model, index 0 = u_rise, 1 = u_any.
    // A filtered bit flips when the last DEBOUNCE+1 synchronized samples
    // all disagree with it; the synchronized value is the pin delayed.
    int unsigned m_s[2]    = '{2, 3};
    int unsigned m_n[2]    = '{4, 2};
    int unsigned m_mode[2] = '{0, 2};
    logic [3:0]  m_filt[2], m_prev[2], m_cap[2], m_mask[2];
    logic [3:0]  pin_hist[2][16];
    logic [3:0]  sync_hist[2][16];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_filt[d] = '0; m_prev[d] = '0; m_cap[d] = '0; m_mask[d] = '0;
            for (int i = 0; i < 16; i++) begin
                pin_hist[d][i]  = '0;
                sync_hist[d][i] = '0;
            end
        end
    endtask

    function automatic logic [3:0] m_edge(input int d);
        case (m_mode[d])
            0:       return m_filt[d] & ~m_prev[d];
            1:       return ~m_filt[d] & m_prev[d];
            default: return m_filt[d] ^ m_prev[d];
        endcase
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, m_filt[d]};
            2'd2:    return {28'h0, m_mask[d]};
            2'd3:    return {28'h0, m_cap[d]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_irq(input int d);
        return |(m_cap[d] & m_mask[d]);
    endfunction

    task automatic model_step(input logic [3:0] p0, input logic [3:0] p1,
                              input logic wr, input logic [1:0] a,
                              input logic [31:0] wd);
        logic [3:0] p, clr, nfilt;
        logic       all_diff;
        for (int d = 0; d < 2; d++) begin
            p   = (d == 0) ? p0 : p1;
            clr = (wr && a == 2'd3) ? wd[3:0] : 4'h0;
            if (wr && a == 2'd2) m_mask[d] = wd[3:0];
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int unsigned i = 0; i <= m_n[d]; i++)
                    if (sync_hist[d][i][b] == m_filt[d][b]) all_diff = 1'b0;
                nfilt[b] = all_diff ? ~m_filt[d][b] : m_filt[d][b];
            end
            m_cap[d]  = (m_cap[d] & ~clr) | m_edge(d);
            m_prev[d] = m_filt[d];
            m_filt[d] = nfilt;
            for (int i = 15; i > 0; i--) pin_hist[d][i] = pin_hist[d][i-1];
            pin_hist[d][0] = p;
            for (int i = 15; i > 0; i--) sync_hist[d][i] = sync_hist[d][i-1];
            sync_hist[d][0] = pin_hist[d][m_s[d]-1];
        end
    endtask

    // One clock: inputs are frozen, the model follows the edge, and the
    // task returns 2 ns after the edge so outputs are sampled off-edge.
    task automatic tick();
        logic [3:0]  p0 = pin_r;
        logic [3:0]  p1 = pin_a;
        logic        wr = chipselect & ~write_n;
        logic [1:0]  a  = address;
        logic [31:0] wd = writedata;
        @(posedge clk);
        if (reset) model_reset();
        else       model_step(p0, p1, wr, a, wd);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #1 reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            tests_run++;
            if (rd_r !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_rise_rd a=%0d got=%h exp=%h", a, rd_r, 32'h0);
            end
            tests_run++;
            if (rd_a !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_any_rd a=%0d got=%h exp=%h", a, rd_a, 32'h0);
            end
        end
        tests_run++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_irq got=%b/%b exp=0/0", irq_r, irq_a);
        end
    endtask

    task automatic test_latency();
        pin_r = 4'h2;
        for (int k = 1; k <= 7; k++) begin
            tick();
            rd(2'd0);
            tests_run++;
            if (rd_r !== ((k == 7) ? 32'h2 : 32'h0)) begin
                tests_failed++;
                $display("FAIL latency_data clk=%0d got=%h exp=%h", k, rd_r,
                         (k == 7) ? 32'h2 : 32'h0);
            end
        end
        rd(2'd3);
        tests_run++;
        if (rd_r !== 32'h0) begin
            tests_failed++;
            $display("FAIL latency_edge_early got=%h exp=%h", rd_r, 32'h0);
        end
        tick();
        rd(2'd3);
        tests_run++;
        if (rd_r !== 32'h2) begin
            tests_failed++;
            $display("FAIL latency_edge got=%h exp=%h", rd_r, 32'h2);
        end
    endtask

    task automatic test_irq();
        bus_write(2'd2, 32'h2);
        tests_run++;
        if (irq_r !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_on got=%b exp=1", irq_r);
        end
        tests_run++;
        if (irq_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_any_quiet got=%b exp=0", irq_a);
        end
        bus_write(2'd3, 32'h2);
        tests_run++;
        if (irq_r !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_clear got=%b exp=0", irq_r);
        end
        rd(2'd3);
        tests_run++;
        if (rd_r !== 32'h0) begin
            tests_failed++;
            $display("FAIL irq_edge_cleared got=%h exp=%h", rd_r, 32'h0);
        end
    endtask

    task automatic test_glitch();
        pin_r = 4'h3;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) pin_r = 4'h2;
            tick();
            rd(2'd0);
            tests_run++;
            if (rd_r !== 32'h2) begin
                tests_failed++;
                $display("FAIL glitch_data clk=%0d got=%h exp=%h", k, rd_r, 32'h2);
            end
            rd(2'd3);
            tests_run++;
            if (rd_r !== 32'h0 || irq_r !== 1'b0) begin
                tests_failed++;
                $display("FAIL glitch_edge clk=%0d got=%h/%b exp=%h/0", k, rd_r, irq_r, 32'h0);
            end
        end
    endtask

    task automatic test_same_cycle();
        pin_r = 4'h3;
        ticks(8);
        rd(2'd3);
        tests_run++;
        if (rd_r !== 32'h1) begin
            tests_failed++;
            $display("FAIL same_pre_capture got=%h exp=%h", rd_r, 32'h1);
        end
        pin_r = 4'h2;
        ticks(7);
        pin_r = 4'h3;
        ticks(7);
        rd(2'd0);
        tests_run++;
        if (rd_r !== 32'h3) begin
            tests_failed++;
            $display("FAIL same_data got=%h exp=%h", rd_r, 32'h3);
        end
        bus_write(2'd3, 32'h1);
        rd(2'd3);
        tests_run++;
        if (rd_r !== 32'h1) begin
            tests_failed++;
            $display("FAIL same_edge_wins got=%h exp=%h", rd_r, 32'h1);
        end
        bus_write(2'd3, 32'h1);
        rd(2'd3);
        tests_run++;
        if (rd_r !== 32'h0) begin
            tests_failed++;
            $display("FAIL same_later_clear got=%h exp=%h", rd_r, 32'h0);
        end
    endtask

    task automatic test_any_edge();
        bus_write(2'd2, 32'hF);
        pin_a = 4'h8;
        ticks(6);
        rd(2'd0);
        tests_run++;
        if (rd_a !== 32'h8) begin
            tests_failed++;
            $display("FAIL any_data_high got=%h exp=%h", rd_a, 32'h8);
        end
        tick();
        rd(2'd3);
        tests_run++;
        if (rd_a !== 32'h8 || irq_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL any_rise_capture got=%h/%b exp=%h/1", rd_a, irq_a, 32'h8);
        end
        bus_write(2'd3, 32'h8);
        rd(2'd3);
        tests_run++;
        if (rd_a !== 32'h0 || irq_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL any_clear got=%h/%b exp=%h/0", rd_a, irq_a, 32'h0);
        end
        pin_a = 4'h0;
        ticks(7);
        rd(2'd3);
        tests_run++;
        if (rd_a !== 32'h8 || irq_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL any_fall_capture got=%h/%b exp=%h/1", rd_a, irq_a, 32'h8);
        end
        bus_write(2'd3, 32'h0);
        rd(2'd3);
        tests_run++;
        if (rd_a !== 32'h8) begin
            tests_failed++;
            $display("FAIL any_write_zero got=%h exp=%h", rd_a, 32'h8);
        end
    endtask

    task automatic test_reset_mid();
        pin_r = 4'h2;
        ticks(7);
        pin_r = 4'h7;
        ticks(8);
        rd(2'd3);
        tests_run++;
        if (rd_r !== 32'h5) begin
            tests_failed++;
            $display("FAIL midrst_pre_edge got=%h exp=%h", rd_r, 32'h5);
        end
        pin_r = 4'hF;
        ticks(4);
        reset = 1'b1;
        model_reset();
        pin_r = 4'h0;
        pin_a = 4'h0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            tests_run++;
            if (rd_r !== 32'h0 || rd_a !== 32'h0) begin
                tests_failed++;
                $display("FAIL midrst_rd a=%0d got=%h/%h exp=0/0", a, rd_r, rd_a);
            end
        end
        tests_run++;
        if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_irq got=%b/%b exp=0/0", irq_r, irq_a);
        end
        ticks(2);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            rd(2'd3);
            tests_run++;
            if (rd_r !== 32'h0 || irq_r !== 1'b0) begin
                tests_failed++;
                $display("FAIL midrst_no_edge clk=%0d got=%h/%b exp=%h/0", k, rd_r, irq_r, 32'h0);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] a;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) == 0) pin_r = pin_r ^ 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) pin_a = pin_a ^ 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) begin
                bus_write(2'($urandom_range(0, 3)), $urandom);
            end else begin
                tick();
            end
            a = 2'($urandom_range(0, 3));
            rd(a);
            tests_run++;
            if (rd_r !== m_read(0, a) || irq_r !== m_irq(0)) begin
                tests_failed++;
                $display("FAIL rand_rise clk=%0d a=%0d got=%h/%b exp=%h/%b",
                         k, a, rd_r, irq_r, m_read(0, a), m_irq(0));
            end
            tests_run++;
            if (rd_a !== m_read(1, a) || irq_a !== m_irq(1)) begin
                tests_failed++;
                $display("FAIL rand_any clk=%0d a=%0d got=%h/%b exp=%h/%b",
                         k, a, rd_a, irq_a, m_read(1, a), m_irq(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_irq();
        test_glitch();
        test_same_cycle();
        test_any_edge();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

endmodule
